fwd_scoreboard: RTL and testbench
=================================

// Module: fwd_scoreboard
// PURPOSE
//  Decode-stage operand bypass and hazard unit, generalising the single-port forwarding select.
//  Serves NREAD source-operand ports and forwards from NFWD in-flight pipeline stages.
//  Keeps a per-register busy scoreboard for long-latency ops (mul/div, multi-cycle mem).
//  Raises one stall to the decode/issue logic and counts stall cycles.
//  Sits between the regfile read ports and the decode->execute pipeline register.
// PARAMETERS
//  XLEN   64  data width
//  NREAD  2   operand read ports
//  NFWD   3   forwarding sources; index 0 = youngest stage (EX), NFWD-1 = oldest
//  NREG   32  architectural registers; address width AW = $clog2(NREG); x0 hard-wired zero
//  CNTW   32  stall counter width
// PORTS
//  clk         in   1           clock
//  reset       in   1           asynchronous, active-high reset
//  ra          in   NREAD*AW    operand register addresses
//  ren         in   NREAD       port i actually uses its operand
//  rd_rf       in   NREAD*XLEN  regfile read data
//  fwd_valid   in   NFWD        stage j holds a register-writing instruction
//  fwd_dst     in   NFWD*AW     stage j destination
//  fwd_data    in   NFWD*XLEN   stage j result
//  fwd_ready   in   NFWD        stage j result is valid this cycle (0 = load still in EX)
//  issue_valid in   1           decode holds an instruction that wants to issue
//  issue_dst   in   AW          its destination (0 = none)
//  issue_long  in   1           it is a long-latency op that writes back via wb_*
//  wb_valid    in   1           long-latency unit writes back this cycle
//  wb_dst      in   AW          long-latency writeback destination
//  wb_data     in   XLEN        long-latency writeback data
//  flush       in   1           pipeline flush; aborts all in-flight long ops
//  result      out  NREAD*XLEN  resolved operands
//  stall       out  1           hold decode and insert a bubble into EX
//  busy_vec    out  NREG        scoreboard, for debug
//  stall_cnt   out  CNTW        stall-cycle count
// BEHAVIOUR
//  Operand select (combinational, zero latency), per port i:
//  - ra[i]==0: result = rd_rf[i]; no hazard.
//  - Otherwise take the lowest j with fwd_valid[j] && fwd_dst[j]==ra[i].
//    Then result = fwd_data[j], and hazard_i = ren[i] && !fwd_ready[j].
//    Older matches are ignored, even when ready.
//  - No stage match and wb_valid && wb_dst==ra[i]: result = wb_data; no hazard.
//    This is the same-cycle clear bypass.
//  - No match at all: result = rd_rf[i]; hazard_i = ren[i] && busy[ra[i]].
//  WAW hazard: issue_dst!=0 && busy[issue_dst]. It holds even if wb clears that bit this same cycle.
//  stall = issue_valid && !flush && (|hazard || waw).
//  Scoreboard (registered; busy[0] is constant 0):
//  - flush=1: next busy = all 0. Overrides issue and wb.
//  - Else, apply two updates in this order:
//    - clear busy[wb_dst] if wb_valid;
//    - set busy[issue_dst] if issue_valid && issue_long && !stall && issue_dst!=0.
//    Set wins over clear on the same register.
//  - wb_valid to a register that is not busy is harmless (clear is a no-op).
//  stall_cnt: +1 on each cycle with stall=1; saturates at all-ones (never wraps).
//  Reset: busy_vec = 0 and stall_cnt = 0, asynchronously.
//  result and stall are combinational from inputs and busy_vec. While reset is high, busy=0 and no busy hazards are raised.
//  Reset mid long-op: busy is lost. A later wb for that register is a no-op clear.
// TESTING
//  1. ra0=5; fwd j0 and j2 both dst 5 (data 0xA, 0xC), all ready -> result0=0xA, stall=0.
//  2. Load-use: ra0=7, ren0=1, j0 dst 7, fwd_ready0=0, issue_valid=1 -> stall=1, stall_cnt+1.
//     Same with ren0=0 -> stall=0.
//  3. Issue long op dst 9 (no stall) -> busy_vec[9]=1 next cycle.
//     Read x9 -> stall until wb_valid, wb_dst=9, wb_data=0x55.
//     In the wb cycle: result=0x55, stall=0; then busy[9]=0.
//  4. busy[4]=1; issue non-long dst 4 -> stall=1 (WAW).
//     flush in a later cycle -> stall=0 that cycle; busy_vec=0 next cycle.
//  5. ra=0 with fwd j0 dst 0, and issue_long dst 0 -> result=rd_rf, no stall, busy[0] stays 0.
//  6. Force stall every cycle from stall_cnt=2^CNTW-2 -> reaches all-ones and holds.
//     Assert reset mid-run -> busy_vec and stall_cnt clear immediately, before the next clk edge.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// Decode-stage operand bypass and hazard unit with a long-latency busy scoreboard.
// Per read port: the youngest matching in-flight stage wins, then a same-cycle
// long-op writeback, then the regfile. Registers still owned by an outstanding
// long-latency op stall decode until their writeback arrives.
module fwd_scoreboard #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned NREAD = 2,
   parameter int unsigned NFWD  = 3,
   parameter int unsigned NREG  = 32,
   parameter int unsigned CNTW  = 32,
   localparam int unsigned AW   = $clog2(NREG)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREAD*AW-1:0]   ra,
   input  logic [NREAD-1:0]      ren,
   input  logic [NREAD*XLEN-1:0] rd_rf,
   input  logic [NFWD-1:0]       fwd_valid,
   input  logic [NFWD*AW-1:0]    fwd_dst,
   input  logic [NFWD*XLEN-1:0]  fwd_data,
   input  logic [NFWD-1:0]       fwd_ready,
   input  logic                  issue_valid,
   input  logic [AW-1:0]         issue_dst,
   input  logic                  issue_long,
   input  logic                  wb_valid,
   input  logic [AW-1:0]         wb_dst,
   input  logic [XLEN-1:0]       wb_data,
   input  logic                  flush,
   output logic [NREAD*XLEN-1:0] result,
   output logic                  stall,
   output logic [NREG-1:0]       busy_vec,
   output logic [CNTW-1:0]       stall_cnt
);

   logic [NREG-1:0]  busy_q, busy_d;
   logic [CNTW-1:0]  stall_cnt_q, stall_cnt_d;
   logic [NREAD-1:0] hazard;
   logic             waw;
   logic             set_en;

   for (genvar gi = 0; gi < NREAD; gi++) begin : g_port
      logic [AW-1:0]   ra_w;
      logic            hit;
      logic            haz;
      logic [XLEN-1:0] data;

      assign ra_w = ra[gi*AW +: AW];

      // Operand select: youngest stage match, else wb bypass, else regfile.
      always_comb begin
         hit  = 1'b0;
         haz  = 1'b0;
         data = rd_rf[gi*XLEN +: XLEN];
         if (ra_w != '0) begin
            for (int j = 0; j < NFWD; j++) begin
               if (!hit && fwd_valid[j] && (fwd_dst[j*AW +: AW] == ra_w)) begin
                  hit  = 1'b1;
                  data = fwd_data[j*XLEN +: XLEN];
                  haz  = ren[gi] && !fwd_ready[j];
               end
            end
            if (!hit) begin
               if (wb_valid && (wb_dst == ra_w)) begin
                  data = wb_data;
               end else begin
                  haz = ren[gi] && busy_q[ra_w];
               end
            end
         end
      end

      assign result[gi*XLEN +: XLEN] = data;
      assign hazard[gi]              = haz;
   end

   // WAW is judged on the registered busy bit, ignoring a same-cycle clear.
   assign waw   = (issue_dst != '0) && busy_q[issue_dst];
   assign stall = issue_valid && !flush && ((|hazard) || waw);

   assign set_en = issue_valid && issue_long && !stall && (issue_dst != '0);

   // Scoreboard next state: flush wipes all, else clear then set (set wins).
   always_comb begin
      busy_d = busy_q;
      if (flush) begin
         busy_d = '0;
      end else begin
         if (wb_valid) begin
            busy_d[wb_dst] = 1'b0;
         end
         if (set_en) begin
            busy_d[issue_dst] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   // Saturating stall-cycle counter.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNTW'(1);
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         busy_q      <= busy_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign busy_vec  = busy_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: expectations are queued as each step is
// driven and drained against the DUT once the step has settled.
module tb_fwd_scoreboard;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned NREAD = 2;
   localparam int unsigned NFWD  = 3;
   localparam int unsigned NREG  = 32;
   localparam int unsigned CNTW  = 4;
   localparam int unsigned AW    = 5;

   localparam int K_RES0 = 0;
   localparam int K_RES1 = 1;
   localparam int K_STALL = 2;
   localparam int K_BUSY = 3;
   localparam int K_CNT = 4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREAD*AW-1:0]   ra;
   logic [NREAD-1:0]      ren;
   logic [NREAD*XLEN-1:0] rd_rf;
   logic [NFWD-1:0]       fwd_valid;
   logic [NFWD*AW-1:0]    fwd_dst;
   logic [NFWD*XLEN-1:0]  fwd_data;
   logic [NFWD-1:0]       fwd_ready;
   logic                  issue_valid;
   logic [AW-1:0]         issue_dst;
   logic                  issue_long;
   logic                  wb_valid;
   logic [AW-1:0]         wb_dst;
   logic [XLEN-1:0]       wb_data;
   logic                  flush;
   logic [NREAD*XLEN-1:0] result;
   logic                  stall;
   logic [NREG-1:0]       busy_vec;
   logic [CNTW-1:0]       stall_cnt;

   fwd_scoreboard #(.XLEN(XLEN), .NREAD(NREAD), .NFWD(NFWD), .NREG(NREG), .CNTW(CNTW)) dut (
      .clk(clk), .reset(reset), .ra(ra), .ren(ren), .rd_rf(rd_rf),
      .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data), .fwd_ready(fwd_ready),
      .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_long(issue_long),
      .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data), .flush(flush),
      .result(result), .stall(stall), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          kind;
      logic [63:0] val;
   } exp_t;

   exp_t        exp_q[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   logic        exp_stall = 1'b0;
   logic [CNTW-1:0] exp_cnt = '0;
   logic [NREG-1:0] exp_busy = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] observe(input int kind);
      case (kind)
         K_RES0:  return result[63:0];
         K_RES1:  return result[127:64];
         K_STALL: return {63'd0, stall};
         K_BUSY:  return 64'(busy_vec);
         default: return 64'(stall_cnt);
      endcase
   endfunction

   task automatic expect_v(input string tag, input int kind, input logic [63:0] v);
      exp_t e;
      e.tag = tag; e.kind = kind; e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic expect_stall(input string tag, input logic v);
      exp_stall = v;
      expect_v(tag, K_STALL, {63'd0, v});
   endtask

   task automatic expect_regs(input string tag);
      expect_v({tag, "_busy"}, K_BUSY, 64'(exp_busy));
      expect_v({tag, "_cnt"}, K_CNT, 64'(exp_cnt));
   endtask

   // Let the current inputs settle, then compare everything queued so far.
   task automatic drain();
      exp_t e;
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(e.tag, observe(e.kind), e.val);
      end
   endtask

   // Advance one clock; the counter model follows the expected stall.
   task automatic tick();
      @(posedge clk);
      if (exp_stall && (exp_cnt != '1)) exp_cnt = exp_cnt + CNTW'(1);
      #1;
   endtask

   task automatic idle();
      ra = '0; ren = '0; rd_rf = '0;
      fwd_valid = '0; fwd_dst = '0; fwd_data = '0; fwd_ready = '1;
      issue_valid = 1'b0; issue_dst = '0; issue_long = 1'b0;
      wb_valid = 1'b0; wb_dst = '0; wb_data = '0; flush = 1'b0;
      exp_stall = 1'b0;
   endtask

   task automatic issue_long_op(input logic [AW-1:0] d);
      idle();
      issue_valid = 1'b1; issue_long = 1'b1; issue_dst = d;
      expect_stall("issue_long_nostall", 1'b0);
      drain();
      tick();
      exp_busy[d] = 1'b1;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      #2;
      expect_regs("reset");
      drain();
      @(negedge clk);
      reset = 1'b0;
      tick();

      // Youngest match wins; port 1 falls through to the regfile.
      idle();
      ra[4:0] = 5'd5; ren = 2'b11; ra[9:5] = 5'd3; rd_rf[127:64] = 64'h33;
      fwd_valid = 3'b101; fwd_dst[4:0] = 5'd5; fwd_dst[14:10] = 5'd5;
      fwd_data[63:0] = 64'hA; fwd_data[191:128] = 64'hC; issue_valid = 1'b1;
      expect_v("t1_res0", K_RES0, 64'hA);
      expect_v("t1_res1", K_RES1, 64'h33);
      expect_stall("t1_stall", 1'b0);
      drain();
      tick();

      // Younger unready match hides an older ready one.
      idle();
      ra[4:0] = 5'd6; ren = 2'b01; issue_valid = 1'b1;
      fwd_valid = 3'b110; fwd_dst[9:5] = 5'd6; fwd_dst[14:10] = 5'd6;
      fwd_data[127:64] = 64'hB; fwd_data[191:128] = 64'hC; fwd_ready = 3'b100;
      expect_v("t1b_res0", K_RES0, 64'hB);
      expect_stall("t1b_stall", 1'b1);
      drain();
      tick();
      expect_regs("t1b_after");
      drain();

      // Load-use on port 0, then the same with ren0 low.
      idle();
      ra[4:0] = 5'd7; ren = 2'b01; issue_valid = 1'b1;
      fwd_valid = 3'b001; fwd_dst[4:0] = 5'd7; fwd_ready = 3'b110;
      expect_stall("t2_loaduse", 1'b1);
      drain();
      tick();
      expect_regs("t2_after");
      ren = 2'b00; exp_stall = 1'b0;
      expect_stall("t2_noren", 1'b0);
      drain();
      tick();
      expect_regs("t2_noren_after");
      drain();

      // Long op to x9, read stalls until the writeback bypass.
      issue_long_op(5'd9);
      expect_regs("t3_set");
      drain();
      idle();
      ra[4:0] = 5'd9; ren = 2'b01; rd_rf[63:0] = 64'h1234; issue_valid = 1'b1;
      expect_v("t3_wait_res", K_RES0, 64'h1234);
      expect_stall("t3_wait", 1'b1);
      drain();
      tick();
      wb_valid = 1'b1; wb_dst = 5'd9; wb_data = 64'h55;
      expect_v("t3_wb_res", K_RES0, 64'h55);
      expect_stall("t3_wb_stall", 1'b0);
      drain();
      tick();
      exp_busy[9] = 1'b0;
      expect_regs("t3_clear");
      drain();

      // WAW holds despite a same-cycle clear; flush then wipes the scoreboard.
      issue_long_op(5'd4);
      issue_long_op(5'd8);
      expect_regs("t4_set");
      drain();
      idle();
      issue_valid = 1'b1; issue_dst = 5'd4; wb_valid = 1'b1; wb_dst = 5'd4;
      expect_stall("t4_waw", 1'b1);
      drain();
      tick();
      exp_busy[4] = 1'b0;
      expect_regs("t4_wbclr");
      drain();
      idle();
      issue_valid = 1'b1; issue_dst = 5'd8; flush = 1'b1;
      expect_stall("t4_flush", 1'b0);
      drain();
      tick();
      exp_busy = '0;
      expect_regs("t4_flushed");
      drain();

      // Set beats a same-cycle clear of a non-busy register.
      idle();
      issue_valid = 1'b1; issue_long = 1'b1; issue_dst = 5'd11;
      wb_valid = 1'b1; wb_dst = 5'd11; wb_data = 64'h77;
      expect_stall("t4b_stall", 1'b0);
      drain();
      tick();
      exp_busy[11] = 1'b1;
      expect_regs("t4b_setwins");
      drain();

      // x0 ignores forwarding and never becomes busy.
      idle();
      ra[4:0] = 5'd0; ren = 2'b01; rd_rf[63:0] = 64'h77;
      fwd_valid = 3'b001; fwd_dst[4:0] = 5'd0; fwd_data[63:0] = 64'h99; fwd_ready = 3'b000;
      issue_valid = 1'b1; issue_long = 1'b1; issue_dst = 5'd0;
      expect_v("t5_res0", K_RES0, 64'h77);
      expect_stall("t5_stall", 1'b0);
      drain();
      tick();
      expect_regs("t5_after");
      drain();

      // Saturate the counter via sustained load-use stalls.
      idle();
      ra[4:0] = 5'd7; ren = 2'b01; issue_valid = 1'b1;
      fwd_valid = 3'b001; fwd_dst[4:0] = 5'd7; fwd_ready = 3'b000;
      for (int k = 0; k < 20; k++) begin
         expect_stall("t6_stall", 1'b1);
         drain();
         tick();
         expect_v("t6_cnt", K_CNT, 64'(exp_cnt));
         drain();
      end
      expect_v("t6_sat", K_CNT, 64'hF);
      drain();

      // Reset between edges clears state immediately and masks busy hazards.
      idle();
      ra[4:0] = 5'd11; ren = 2'b01; issue_valid = 1'b1;
      expect_stall("t6_busyhaz", 1'b1);
      drain();
      #2;
      reset = 1'b1;
      exp_busy = '0; exp_cnt = '0; exp_stall = 1'b0;
      expect_regs("t6_rst");
      expect_stall("t6_rst_stall", 1'b0);
      drain();
      @(negedge clk);
      reset = 1'b0;
      idle();
      wb_valid = 1'b1; wb_dst = 5'd11;
      tick();
      expect_regs("t6_postrst");
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
